// File: rtl/btb_predictor_ss_if.sv
// btb_predictor_ss_if: lookup, prediction and training signals of the branch target buffer
interface btb_predictor_ss_if #(parameter int SUPER = 2, parameter int PC_W = 32);
  logic                  lookup_valid;
  logic [SUPER*PC_W-1:0] lookup_pc;
  logic [SUPER-1:0]      lookup_is_branch;
  logic [SUPER-1:0]      lookup_is_jump;
  logic                  pred_valid;
  logic [SUPER-1:0]      pred_taken;
  logic [PC_W-1:0]       pred_next_pc;
  logic                  upd_valid;
  logic [PC_W-1:0]       upd_pc;
  logic                  upd_taken;
  logic [PC_W-1:0]       upd_target;
  logic                  flush;
  modport master (
    output lookup_valid, lookup_pc, lookup_is_branch, lookup_is_jump,
    output upd_valid, upd_pc, upd_taken, upd_target, flush,
    input  pred_valid, pred_taken, pred_next_pc
  );
  modport slave (
    input  lookup_valid, lookup_pc, lookup_is_branch, lookup_is_jump,
    input  upd_valid, upd_pc, upd_taken, upd_target, flush,
    output pred_valid, pred_taken, pred_next_pc
  );
endinterface

// File: rtl/btb_predictor_ss.sv
// btb_predictor_ss: set-associative BTB with 2-bit counters and per-set round-robin allocation; BTB_STATS_EN adds stat counters
module btb_predictor_ss #(
  parameter int SUPER = 2,
  parameter int WAYS  = 4,
  parameter int SETS  = 64,
  parameter int PC_W  = 32
) (
  input  logic clk,
  input  logic rst,
  btb_predictor_ss_if.slave bus
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_allocs
`endif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam int RR_W  = WAYS > 1 ? $clog2(WAYS) : 1;
  logic             v      [WAYS][SETS];
  logic [TAG_W-1:0] tag_q  [WAYS][SETS];
  logic [PC_W-1:0]  tgt_q  [WAYS][SETS];
  logic [1:0]       ctr_q  [WAYS][SETS];
  logic [RR_W-1:0]  rr     [SETS];
  logic [PC_W-1:0]  lpc    [SUPER];
  logic [PC_W-1:0]  htgt   [SUPER];
  logic [SUPER-1:0] hit, hbit, tk, sel;
  logic [PC_W-1:0]  npc;
  logic [IDX_W-1:0] uidx;
  logic [TAG_W-1:0] utag;
  logic [RR_W-1:0]  uway;
  logic [1:0]       uctr;
  logic             uhit, alloc;
  logic             unused;
  for (genvar g = 0; g < SUPER; g++) begin : g_pc
    assign lpc[g] = bus.lookup_pc[g*PC_W +: PC_W];
  end
  assign uidx   = bus.upd_pc[IDX_W+1:2];
  assign utag   = bus.upd_pc[PC_W-1:IDX_W+2];
  assign uctr   = ctr_q[uway][uidx];
  assign alloc  = bus.upd_valid && !bus.flush && !uhit && bus.upd_taken;
  assign unused = ^{bus.lookup_pc, bus.upd_pc};
  // ways scanned high to low so the lowest matching way wins
  always_comb begin
    for (int s = 0; s < SUPER; s++) begin
      hit[s]  = 1'b0;
      hbit[s] = 1'b0;
      htgt[s] = '0;
      for (int w = WAYS - 1; w >= 0; w--)
        if (v[w][lpc[s][IDX_W+1:2]] && tag_q[w][lpc[s][IDX_W+1:2]] == lpc[s][PC_W-1:IDX_W+2]) begin
          hit[s]  = 1'b1;
          hbit[s] = ctr_q[w][lpc[s][IDX_W+1:2]][1];
          htgt[s] = tgt_q[w][lpc[s][IDX_W+1:2]];
        end
      tk[s] = hit[s] && (bus.lookup_is_jump[s] || (bus.lookup_is_branch[s] && hbit[s]));
    end
    sel = '0;
    npc = lpc[SUPER-1] + PC_W'(4);
    for (int s = SUPER - 1; s >= 0; s--)
      if (tk[s]) begin
        sel    = '0;
        sel[s] = 1'b1;
        npc    = htgt[s];
      end
  end
  always_comb begin
    uhit = 1'b0;
    uway = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (v[w][uidx] && tag_q[w][uidx] == utag) begin
        uhit = 1'b1;
        uway = RR_W'(w);
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.pred_valid   <= 1'b0;
      bus.pred_taken   <= '0;
      bus.pred_next_pc <= '0;
      for (int i = 0; i < SETS; i++) begin
        rr[i] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          v[w][i]     <= 1'b0;
          tag_q[w][i] <= '0;
          tgt_q[w][i] <= '0;
          ctr_q[w][i] <= 2'b01;
        end
      end
    end else begin
      bus.pred_valid <= bus.lookup_valid;
      if (bus.lookup_valid) begin
        bus.pred_taken   <= sel;
        bus.pred_next_pc <= npc;
      end
      if (bus.flush) begin
        for (int i = 0; i < SETS; i++)
          for (int w = 0; w < WAYS; w++)
            v[w][i] <= 1'b0;
      end else if (bus.upd_valid && uhit) begin
        ctr_q[uway][uidx] <= bus.upd_taken ? (uctr == 2'd3 ? uctr : uctr + 2'd1)
                                           : (uctr == 2'd0 ? uctr : uctr - 2'd1);
        if (bus.upd_taken) tgt_q[uway][uidx] <= bus.upd_target;
      end else if (alloc) begin
        v[rr[uidx]][uidx]     <= 1'b1;
        tag_q[rr[uidx]][uidx] <= utag;
        tgt_q[rr[uidx]][uidx] <= bus.upd_target;
        ctr_q[rr[uidx]][uidx] <= 2'b10;
        rr[uidx]              <= rr[uidx] == RR_W'(WAYS - 1) ? '0 : rr[uidx] + RR_W'(1);
      end
    end
  end
`ifdef BTB_STATS_EN
  logic [32:0] lk_sum, hit_sum;
  always_comb begin
    lk_sum  = {1'b0, stat_lookups};
    hit_sum = {1'b0, stat_hits};
    for (int s = 0; s < SUPER; s++)
      if (bus.lookup_valid && (bus.lookup_is_branch[s] || bus.lookup_is_jump[s])) begin
        lk_sum  = lk_sum + 33'd1;
        hit_sum = hit_sum + {32'd0, hit[s]};
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lookups <= '0;
      stat_hits    <= '0;
      stat_allocs  <= '0;
    end else begin
      stat_lookups <= lk_sum[32] ? '1 : lk_sum[31:0];
      stat_hits    <= hit_sum[32] ? '1 : hit_sum[31:0];
      stat_allocs  <= stat_allocs + {31'd0, alloc && stat_allocs != '1};
    end
  end
`endif
endmodule

// File: tb/tb_btb_predictor_ss.sv
// tb_btb_predictor_ss: scoreboard bench comparing the BTB against an entry-table reference model
module tb_btb_predictor_ss;
  localparam int SUPER = 2, WAYS = 4, SETS = 64, PC_W = 32;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  btb_predictor_ss_if #(.SUPER(SUPER), .PC_W(PC_W)) bus ();
`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups, stat_hits, stat_allocs;
`endif
  btb_predictor_ss #(.SUPER(SUPER), .WAYS(WAYS), .SETS(SETS), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef BTB_STATS_EN
    , .stat_lookups(stat_lookups), .stat_hits(stat_hits), .stat_allocs(stat_allocs)
`endif
  );
  typedef struct { bit v; logic [31:0] tag; logic [31:0] tgt; int ctr; } ent_t;
  typedef struct { logic [SUPER-1:0] tk; logic [31:0] npc; } exp_t;
  ent_t m [SETS][WAYS];
  int   rrm [SETS];
  exp_t q[$];
  exp_t last;
  bit   exp_pv, primed;
  int   checks = 0, errors = 0;

  function automatic int find(input logic [31:0] pc);
    int i = int'((pc >> 2) % SETS);
    for (int w = 0; w < WAYS; w++)
      if (m[i][w].v && m[i][w].tag == (pc >> 8)) return w;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SETS; i++) begin
      rrm[i] = 0;
      for (int w = 0; w < WAYS; w++) m[i][w] = '{0, 32'd0, 32'd0, 1};
    end
  endtask

  // one clock: check last response/hold, predict this lookup, apply training to the model
  task automatic tick();
    exp_t e;
    logic [31:0] pc;
    int w, i;
    if (primed) begin
      checks++;
      if (bus.pred_valid !== exp_pv ||
          (!exp_pv && (bus.pred_taken !== last.tk || bus.pred_next_pc !== last.npc))) begin
        errors++;
        $display("FAIL hold_valid: got v=%0b tk=%b pc=%h, want v=%0b tk=%b pc=%h",
                 bus.pred_valid, bus.pred_taken, bus.pred_next_pc, exp_pv, last.tk, last.npc);
      end
    end
    primed = 1;
    if (rst) begin
      model_reset();
      exp_pv = 0;
      last   = '{'0, 32'd0};
    end else begin
      exp_pv = bus.lookup_valid;
      if (bus.lookup_valid) begin
        e.tk  = '0;
        e.npc = bus.lookup_pc[(SUPER-1)*32 +: 32] + 32'd4;
        for (int s = SUPER - 1; s >= 0; s--) begin
          pc = bus.lookup_pc[s*32 +: 32];
          w  = find(pc);
          if (w >= 0 && (bus.lookup_is_jump[s] ||
                         (bus.lookup_is_branch[s] && m[int'((pc >> 2) % SETS)][w].ctr >= 2))) begin
            e.tk    = '0;
            e.tk[s] = 1'b1;
            e.npc   = m[int'((pc >> 2) % SETS)][w].tgt;
          end
        end
        q.push_back(e);
        last = e;
      end
      i = int'((bus.upd_pc >> 2) % SETS);
      w = find(bus.upd_pc);
      if (bus.flush) begin
        for (int a = 0; a < SETS; a++)
          for (int b = 0; b < WAYS; b++) m[a][b].v = 0;
      end else if (bus.upd_valid && w >= 0) begin
        m[i][w].ctr = bus.upd_taken ? (m[i][w].ctr == 3 ? 3 : m[i][w].ctr + 1)
                                    : (m[i][w].ctr == 0 ? 0 : m[i][w].ctr - 1);
        if (bus.upd_taken) m[i][w].tgt = bus.upd_target;
      end else if (bus.upd_valid && bus.upd_taken) begin
        m[i][rrm[i]] = '{1, bus.upd_pc >> 8, bus.upd_target, 2};
        rrm[i] = (rrm[i] + 1) % WAYS;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit lv, input logic [31:0] p0, input logic [31:0] p1,
                       input logic [1:0] br, input logic [1:0] jm,
                       input bit uv, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utg, input bit fl);
    bus.lookup_valid     = lv;
    bus.lookup_pc        = {p1, p0};
    bus.lookup_is_branch = br;
    bus.lookup_is_jump   = jm;
    bus.upd_valid        = uv;
    bus.upd_pc           = upc;
    bus.upd_taken        = ut;
    bus.upd_target       = utg;
    bus.flush            = fl;
    tick();
  endtask

  task automatic look(input logic [31:0] p0, input logic [31:0] p1, input logic [1:0] br,
                      input logic [1:0] jm);
    drive(1, p0, p1, br, jm, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] tg);
    drive(0, 0, 0, 0, 0, 1, pc, t, tg, 0);
  endtask

  function automatic logic [31:0] rpc(input int t, input int i);
    return (32'(t) << 8) | (32'(i) << 2);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.pred_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL pred_unexpected: got tk=%b pc=%h, want no response",
                 bus.pred_taken, bus.pred_next_pc);
      end else begin
        e = q.pop_front();
        if (bus.pred_taken !== e.tk || bus.pred_next_pc !== e.npc) begin
          errors++;
          $display("FAIL pred: got tk=%b pc=%h, want tk=%b pc=%h",
                   bus.pred_taken, bus.pred_next_pc, e.tk, e.npc);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    primed = 0;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    look(32'h100, 32'h104, 2'b11, 2'b00);
    upd(32'h104, 1, 32'h400);
    look(32'h100, 32'h104, 2'b11, 2'b00);
    upd(32'h104, 0, 32'h0);
    look(32'h100, 32'h104, 2'b11, 2'b00);
    repeat (4) upd(32'h104, 1, 32'h400);
    upd(32'h104, 0, 32'h0);
    look(32'h100, 32'h104, 2'b11, 2'b00);
    upd(32'h104, 0, 32'h0);
    look(32'h100, 32'h104, 2'b11, 2'b00);
    upd(32'h100, 1, 32'h200);
    upd(32'h104, 1, 32'h400);
    look(32'h100, 32'h104, 2'b11, 2'b00);
    for (int t = 1; t <= WAYS + 1; t++) upd(rpc(t, 5), 1, 32'(t) << 4);
    for (int t = 1; t <= WAYS + 1; t++) look(rpc(t, 5), 32'h0, 2'b01, 2'b00);
    upd(rpc(9, 5), 1, 32'h990);
    look(rpc(2, 5), rpc(9, 5), 2'b11, 2'b00);
    drive(0, 0, 0, 0, 0, 1, 32'h3000, 1, 32'h3300, 1);
    look(32'h100, 32'h104, 2'b11, 2'b11);
    look(32'h3000, 32'h3004, 2'b01, 2'b01);
    drive(1, 32'h500, 32'h504, 2'b00, 2'b01, 1, 32'h500, 1, 32'h700, 0);
    look(32'h500, 32'h504, 2'b00, 2'b01);
    look(32'hFFFF_FFF8, 32'hFFFF_FFFC, 2'b11, 2'b00);
    bus.lookup_valid = 1'b0;
    tick();
    rst = 1'b1;
    look(32'h500, 32'h504, 2'b00, 2'b01);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] p0, p1;
      p0 = rpc($urandom_range(0, 5), $urandom_range(0, 2));
      p1 = $urandom_range(0, 1) ? p0 + 32'd4 : rpc($urandom_range(0, 5), $urandom_range(0, 2));
      drive($urandom_range(0, 3) != 0, p0, p1, 2'($urandom), 2'($urandom),
            $urandom_range(0, 1) == 1, rpc($urandom_range(0, 5), $urandom_range(0, 2)),
            $urandom_range(0, 9) < 7, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 63) == 0);
    end
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending responses, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/btb_predictor_ss.md
# btb_predictor_ss

Parametrised, set-associative branch target buffer with per-entry 2-bit saturating counters, serving `SUPER` fetch slots per cycle. It sits between fetch/decode (lookup) and execute (training). It returns a registered prediction of the next fetch PC one cycle after lookup. Training is done only on resolved branches, never speculatively, and allocation uses a per-set round-robin replacement pointer.

## Interface
Parameters:
- `SUPER`, 2: fetch slots looked up per cycle (≥1).
- `WAYS`, 4: associativity (≥1, power of two).
- `SETS`, 64: sets per way (power of two); `IDX_W = $clog2(SETS)`.
- `PC_W`, 32: PC width; tag = `pc[PC_W-1:IDX_W+2]`, index = `pc[IDX_W+1:2]`.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `lookup_valid`  in  1  lookup request this cycle.
- `lookup_pc`  in  `SUPER*PC_W`  PC per slot; slot 0 is the oldest.
- `lookup_is_branch`  in  `SUPER`  slot holds a conditional branch.
- `lookup_is_jump`  in  `SUPER`  slot holds an unconditional jump.
- `pred_valid`  out  1  registered response valid.
- `pred_taken`  out  `SUPER`  one-hot (or zero); marks the earliest predicted-taken slot.
- `pred_next_pc`  out  `PC_W`  predicted next fetch PC.
- `upd_valid`  in  1  resolved-branch training request.
- `upd_pc`  in  `PC_W`  PC of the resolved instruction.
- `upd_taken`  in  1  actual direction (1 for jumps).
- `upd_target`  in  `PC_W`  actual taken target.
- `flush`  in  1  invalidate all entries.

## Operation
- Entry fields: `valid`, `tag`, `target[PC_W]`, `ctr[1:0]`. Each set has one round-robin pointer `rr[$clog2(WAYS)]`.
- Hit condition for slot i: some way has `valid` set and a matching tag at the slot's index. If several ways match, the lowest-numbered way wins.
- Slot i is taken-predicted when it hits and either `lookup_is_jump[i]=1`, or `lookup_is_branch[i]=1` and `ctr[1]=1`.
- The earliest taken-predicted slot k sets `pred_taken` to the one-hot for k, and `pred_next_pc = target` of k.
- If no slot is taken-predicted: `pred_taken=0` and `pred_next_pc = lookup_pc[SUPER-1]+4`, truncated to `PC_W` (wraps at the top of the address space).
- Training on `upd_valid`, hit:
  - `ctr` increments if `upd_taken`, saturating at 3; otherwise decrements, saturating at 0.
  - `target` is overwritten only when `upd_taken=1`.
- Training on `upd_valid`, miss, `upd_taken=1`: allocate into way `rr[idx]` with `valid=1`, tag, target and `ctr=2'b10`. Then `rr[idx]` advances by 1 mod `WAYS`. The victim's valid bit is not considered.
- Training on `upd_valid`, miss, `upd_taken=0`: no state change.
- `flush` clears every `valid` bit. Counters, targets and `rr` are kept. `flush` has priority over a same-cycle update, which is dropped.
- Priority: `rst` > `flush` > update.

## Timing
- Lookup latency is 1 cycle. `pred_*` are registered from the cycle-N lookup and are valid in cycle N+1. `pred_valid = lookup_valid` delayed one cycle.
- When `lookup_valid=0`, `pred_taken` and `pred_next_pc` hold their previous values and `pred_valid=0`.
- Updates commit at the clock edge. A lookup in the same cycle reads pre-update state (no bypass). A lookup in the next cycle sees the update.
- One update per cycle; there is no back-pressure.
- Reset values: `pred_valid=0`, `pred_taken=0`, `pred_next_pc=0`. All entries have `valid=0`, `tag=0`, `target=0`, `ctr=2'b01`, and every `rr=0`.
- Reset asserted mid-stream discards the in-flight response: `pred_valid=0` in the cycle after reset.

## Configuration
- `BTB_STATS_EN`:
  - Defined: adds outputs `stat_lookups`, `stat_hits` and `stat_allocs`, each 32 bits, saturating, and zeroed on `rst` (not on `flush`).
  - `stat_lookups` counts each slot that has `lookup_valid` and is a branch or jump.
  - `stat_hits` counts the subset of those slots that hit.
  - `stat_allocs` counts miss allocations.
  - Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- **Reset and cold lookup.** Reset, then lookup `pc={0x100,0x104}` with branch flags `2'b11` → next cycle `pred_valid=1`, `pred_taken=0`, `pred_next_pc=0x108`.
- **Allocate and predict.** Update `0x104` taken, target `0x400` → next-cycle lookup of the same pair gives `pred_taken=2'b10`, `pred_next_pc=0x400`, `ctr=2'b10`.
- **Counter hysteresis and saturation.** Allocated entry trained not-taken once → predicts not-taken (`0x108`). Train taken three times → `ctr=3`, and a further taken update leaves it at 3.
- **Earliest-slot priority.** Both slots allocated taken (targets `0x200`, `0x400`) → `pred_taken=2'b01`, `pred_next_pc=0x200`.
- **Round-robin replacement.** `WAYS+1` distinct tags at one index, all taken → the first tag misses afterwards, the other `WAYS` hit, and `rr` wraps to 1.
- **Flush versus update, and same-cycle read.** `flush` with `upd_valid` in the same cycle → all lookups miss and the update is dropped. An update and a lookup to the same PC in one cycle → that response misses, and the next-cycle lookup hits.
